// File: rtl/packet_loader_pkg.sv
`default_nettype none
// ============================================================================
// packet_loader_pkg : widths, field ranges, opcodes and template merge helper
// Revision: 1.0
// ============================================================================
package packet_loader_pkg;

    localparam int PACKET_WIDTH         = 175;
    localparam int PACKET_REQUEST_WIDTH = 108;

    localparam logic [1:0] OPCODE_EI = 2'd0;
    localparam logic [1:0] OPCODE_FN = 2'd1;
    localparam logic [1:0] OPCODE_MA = 2'd2;

    localparam logic [2:0] DEST_OPTION_EXEC  = 3'd0;
    localparam logic [2:0] DEST_OPTION_ONE   = 3'd1;
    localparam logic [2:0] DEST_OPTION_LEFT  = 3'd2;
    localparam logic [2:0] DEST_OPTION_RIGHT = 3'd3;

    localparam int REQ_OPT_MSB   = 107;
    localparam int REQ_OPT_LSB   = 105;
    localparam int REQ_ADDR_MSB  = 104;
    localparam int REQ_ADDR_LSB  = 89;
    localparam int DATA1_MSB     = 88;
    localparam int DATA1_LSB     = 57;
    localparam int DATA2_MSB     = 56;
    localparam int DATA2_LSB     = 25;
    localparam int TAG_MSB       = 24;
    localparam int TAG_LSB       = 0;
    localparam int PKT_MODE_MSB  = 174;
    localparam int PKT_MODE_LSB  = 173;
    localparam int PKT_OPC_MSB   = 172;
    localparam int PKT_OPC_LSB   = 165;
    localparam int PKT_DEST_MSB  = 164;
    localparam int PKT_DEST_LSB  = 89;

    typedef logic [PACKET_WIDTH-1:0]         packet_t;
    typedef logic [PACKET_REQUEST_WIDTH-1:0] request_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Request fields override the template; options 4-7 behave as EXEC.
    function automatic packet_t make_packet_from_request(request_t req, packet_t tmpl);
        packet_t pkt;
        pkt = tmpl;
        pkt[TAG_MSB:TAG_LSB] = req[TAG_MSB:TAG_LSB];
        case (req[REQ_OPT_MSB:REQ_OPT_LSB])
            DEST_OPTION_LEFT:  pkt[DATA1_MSB:DATA1_LSB] = req[DATA1_MSB:DATA1_LSB];
            DEST_OPTION_RIGHT: pkt[DATA2_MSB:DATA2_LSB] = req[DATA2_MSB:DATA2_LSB];
            default: begin
                pkt[DATA1_MSB:DATA1_LSB] = req[DATA1_MSB:DATA1_LSB];
                pkt[DATA2_MSB:DATA2_LSB] = req[DATA2_MSB:DATA2_LSB];
            end
        endcase
        return pkt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/packet_loader_if.sv
`default_nettype none
// ============================================================================
// packet_loader_if : memory, request and packet-output handshake bundle
// Revision: 1.0
// ============================================================================
interface packet_loader_if;
    import packet_loader_pkg::*;

    logic          MEM_SEND_ADDR_VALID;
    logic [31:0]   MEM_SEND_ADDR;
    logic          MEM_SEND_READY;
    logic          MEM_SEND_DATA_VALID;
    logic [31:0]   MEM_SEND_DATA;
    logic          MEM_RECEIVE_VALID;
    logic [31:0]   MEM_RECEIVE_DATA;
    logic          MEM_RECEIVE_READY;
    logic          RECEIVE_PR_VALID;
    request_t      RECEIVE_PR_DATA;
    logic          RECEIVE_PR_READY;
    logic          SEND_PC_TO_QU_VALID;
    packet_t       SEND_PC_TO_QU_DATA;
    logic          SEND_PC_TO_QU_READY;
    logic          SEND_PC_TO_FE_VALID;
    packet_t       SEND_PC_TO_FE_DATA;
    logic          SEND_PC_TO_FE_READY;
    logic          SEND_PC_TO_MA_VALID;
    packet_t       SEND_PC_TO_MA_DATA;
    logic          SEND_PC_TO_MA_READY;

    modport master (
        output MEM_SEND_ADDR_VALID, MEM_SEND_ADDR, MEM_SEND_DATA_VALID, MEM_SEND_DATA,
        output MEM_RECEIVE_READY, RECEIVE_PR_READY,
        output SEND_PC_TO_QU_VALID, SEND_PC_TO_QU_DATA,
        output SEND_PC_TO_FE_VALID, SEND_PC_TO_FE_DATA,
        output SEND_PC_TO_MA_VALID, SEND_PC_TO_MA_DATA,
        input  MEM_SEND_READY, MEM_RECEIVE_VALID, MEM_RECEIVE_DATA,
        input  RECEIVE_PR_VALID, RECEIVE_PR_DATA,
        input  SEND_PC_TO_QU_READY, SEND_PC_TO_FE_READY, SEND_PC_TO_MA_READY
    );

    modport slave (
        input  MEM_SEND_ADDR_VALID, MEM_SEND_ADDR, MEM_SEND_DATA_VALID, MEM_SEND_DATA,
        input  MEM_RECEIVE_READY, RECEIVE_PR_READY,
        input  SEND_PC_TO_QU_VALID, SEND_PC_TO_QU_DATA,
        input  SEND_PC_TO_FE_VALID, SEND_PC_TO_FE_DATA,
        input  SEND_PC_TO_MA_VALID, SEND_PC_TO_MA_DATA,
        output MEM_SEND_READY, MEM_RECEIVE_VALID, MEM_RECEIVE_DATA,
        output RECEIVE_PR_VALID, RECEIVE_PR_DATA,
        output SEND_PC_TO_QU_READY, SEND_PC_TO_FE_READY, SEND_PC_TO_MA_READY
    );

endinterface
`default_nettype wire

// File: rtl/packet_loader.sv
`default_nettype none
// ============================================================================
// packet_loader : fetches a six-word instruction template, merges the request
// and routes the packet to QU/FE/MA. PACKET_LOADER_ERR_EN adds a sticky ERR.
// Revision: 1.0
// ============================================================================
module packet_loader
    import packet_loader_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] OPADDR,
`ifdef PACKET_LOADER_ERR_EN
    output logic        ERR,
`endif
    packet_loader_if.master bus
);

    state_t      r_state, w_next_state;
    logic [2:0]  r_count, w_next_count;
    request_t    r_req;
    logic [31:0] r_words [0:4];
    packet_t     r_packet, w_merged;
    logic [31:0] r_addr, w_next_addr;
    logic [15:0] w_dest_addr;
    logic [1:0]  w_opmode, w_out_opmode;
    logic        r_pr_ready, r_addr_valid, r_rcv_ready;
    logic        r_qu_valid, r_fe_valid, r_ma_valid;
    logic        w_accept, w_addr_xfer, w_data_xfer, w_out_xfer, w_last_word, w_illegal;

    assign w_accept    = (r_state == ST_IDLE) && r_pr_ready && bus.RECEIVE_PR_VALID;
    assign w_addr_xfer = (r_state == ST_ADDR) && r_addr_valid && bus.MEM_SEND_READY;
    assign w_data_xfer = (r_state == ST_DATA) && r_rcv_ready && bus.MEM_RECEIVE_VALID;
    assign w_out_xfer  = (r_state == ST_OUT) &&
                         ((r_qu_valid && bus.SEND_PC_TO_QU_READY) ||
                          (r_fe_valid && bus.SEND_PC_TO_FE_READY) ||
                          (r_ma_valid && bus.SEND_PC_TO_MA_READY));
    assign w_last_word = (r_count == 3'd5);

    // The sixth word is merged straight off the bus so OUT follows without a bubble.
    assign w_merged  = make_packet_from_request(r_req,
                           {r_words[0], r_words[1], r_words[2], r_words[3], r_words[4],
                            bus.MEM_RECEIVE_DATA[14:0]});
    assign w_opmode  = w_merged[PKT_MODE_MSB:PKT_MODE_LSB];
    assign w_illegal = (w_opmode == 2'd3);
    assign w_out_opmode = (r_state == ST_OUT) ? r_packet[PKT_MODE_MSB:PKT_MODE_LSB] : w_opmode;

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_dest_addr  = r_req[REQ_ADDR_MSB:REQ_ADDR_LSB];
        case (r_state)
            ST_IDLE: if (w_accept) begin
                w_next_state = ST_ADDR;
                w_next_count = 3'd0;
                w_dest_addr  = bus.RECEIVE_PR_DATA[REQ_ADDR_MSB:REQ_ADDR_LSB];
            end
            ST_ADDR: if (w_addr_xfer) w_next_state = ST_DATA;
            ST_DATA: if (w_data_xfer) begin
                if (w_last_word) begin
                    w_next_state = w_illegal ? ST_IDLE : ST_OUT;
                end else begin
                    w_next_state = ST_ADDR;
                    w_next_count = r_count + 3'd1;
                end
            end
            ST_OUT:  if (w_out_xfer) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        w_next_addr = OPADDR + {16'b0, w_dest_addr} + {27'b0, w_next_count, 2'b00};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_count <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pr_ready   <= 1'b0;
            r_addr_valid <= 1'b0;
            r_rcv_ready  <= 1'b0;
            r_qu_valid   <= 1'b0;
            r_fe_valid   <= 1'b0;
            r_ma_valid   <= 1'b0;
            r_req        <= '0;
            r_addr       <= '0;
            r_packet     <= '0;
            for (int i = 0; i < 5; i++) r_words[i] <= '0;
        end else begin
            r_pr_ready   <= (w_next_state == ST_IDLE);
            r_addr_valid <= (w_next_state == ST_ADDR);
            r_rcv_ready  <= (w_next_state == ST_DATA);
            r_qu_valid   <= (w_next_state == ST_OUT) && (w_out_opmode == OPCODE_EI);
            r_fe_valid   <= (w_next_state == ST_OUT) && (w_out_opmode == OPCODE_FN);
            r_ma_valid   <= (w_next_state == ST_OUT) && (w_out_opmode == OPCODE_MA);
            if (w_accept) r_req <= bus.RECEIVE_PR_DATA;
            if ((w_next_state == ST_ADDR) && (r_state != ST_ADDR)) r_addr <= w_next_addr;
            if (w_data_xfer && !w_last_word) r_words[r_count] <= bus.MEM_RECEIVE_DATA;
            if (w_data_xfer && w_last_word && !w_illegal) r_packet <= w_merged;
        end
    end

`ifdef PACKET_LOADER_ERR_EN
    logic r_err;
    always_ff @(posedge CLK) begin
        if (RST) r_err <= 1'b0;
        else if (w_data_xfer && w_last_word && w_illegal) r_err <= 1'b1;
    end
    assign ERR = r_err;
`else
    // Opmode-3 packets are dropped without any indication.
`endif

    assign bus.RECEIVE_PR_READY    = r_pr_ready;
    assign bus.MEM_SEND_ADDR_VALID = r_addr_valid;
    assign bus.MEM_SEND_ADDR       = r_addr;
    assign bus.MEM_SEND_DATA_VALID = 1'b0;
    assign bus.MEM_SEND_DATA       = 32'd0;
    assign bus.MEM_RECEIVE_READY   = r_rcv_ready;
    assign bus.SEND_PC_TO_QU_VALID = r_qu_valid;
    assign bus.SEND_PC_TO_FE_VALID = r_fe_valid;
    assign bus.SEND_PC_TO_MA_VALID = r_ma_valid;
    assign bus.SEND_PC_TO_QU_DATA  = r_packet;
    assign bus.SEND_PC_TO_FE_DATA  = r_packet;
    assign bus.SEND_PC_TO_MA_DATA  = r_packet;

endmodule
`default_nettype wire

// File: tb/tb_packet_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_packet_loader : directed scoreboard bench for packet_loader
// Revision: 1.0
// ============================================================================
module tb_packet_loader;
    import packet_loader_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] OPADDR = 32'd0;
`ifdef PACKET_LOADER_ERR_EN
    logic        ERR;
`endif
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr_q [$];
    logic [176:0] exp_pkt_q [$];

    packet_loader_if bus ();

    packet_loader dut (
        .CLK    (CLK),
        .RST    (RST),
        .OPADDR (OPADDR),
`ifdef PACKET_LOADER_ERR_EN
        .ERR    (ERR),
`endif
        .bus    (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [174:0] model(input logic [107:0] req, input logic [174:0] tmpl);
        logic [174:0] p;
        p = tmpl;
        p[24:0] = req[24:0];
        if (req[107:105] == 3'd2)      p[88:57] = req[88:57];
        else if (req[107:105] == 3'd3) p[56:25] = req[56:25];
        else begin
            p[88:57] = req[88:57];
            p[56:25] = req[56:25];
        end
        return p;
    endfunction

    function automatic logic [5:0] all_hs();
        return {bus.RECEIVE_PR_READY, bus.MEM_SEND_ADDR_VALID, bus.MEM_RECEIVE_READY,
                bus.SEND_PC_TO_QU_VALID, bus.SEND_PC_TO_FE_VALID, bus.SEND_PC_TO_MA_VALID};
    endfunction

    task automatic run_packet(input logic [31:0] base, input logic [107:0] req,
                              input logic [174:0] tmpl, input logic [16:0] w5_hi,
                              input bit stall, input bit drop);
        logic [31:0]  words [6];
        logic [31:0]  obs_addr;
        logic [174:0] obs_pkt;
        logic [176:0] e;
        logic [2:0]   vld;
        int           k;
        int           t0;
        bit           seen;
        for (int i = 0; i < 5; i++) words[i] = tmpl[174 - 32*i -: 32];
        words[5] = {w5_hi, tmpl[14:0]};
        OPADDR = base;
        for (int i = 0; i < 6; i++) exp_addr_q.push_back(base + {16'b0, req[104:89]} + 32'(4*i));
        if (!drop) exp_pkt_q.push_back({tmpl[174:173], model(req, tmpl)});

        bus.RECEIVE_PR_VALID = 1'b1;
        bus.RECEIVE_PR_DATA  = req;
        k = 0;
        while (!bus.RECEIVE_PR_READY && k < 50) begin @(negedge CLK); k++; end
        check("pr_ready", bus.RECEIVE_PR_READY, 1);
        @(negedge CLK);
        t0 = cyc;
        bus.RECEIVE_PR_VALID = 1'b0;
        bus.RECEIVE_PR_DATA  = 108'($urandom);

        for (int i = 0; i < 6; i++) begin
            k = 0;
            while (!bus.MEM_SEND_ADDR_VALID && k < 50) begin @(negedge CLK); k++; end
            check("addr_valid", bus.MEM_SEND_ADDR_VALID, 1);
            obs_addr = bus.MEM_SEND_ADDR;
            if (stall) repeat (3) begin
                @(negedge CLK);
                check("addr_hold", {bus.MEM_SEND_ADDR_VALID, bus.MEM_SEND_ADDR}, {1'b1, obs_addr});
            end
            bus.MEM_SEND_READY = 1'b1;
            @(negedge CLK);
            bus.MEM_SEND_READY = 1'b0;
            check("mem_addr", obs_addr, exp_addr_q.pop_front());
            k = 0;
            while (!bus.MEM_RECEIVE_READY && k < 50) begin @(negedge CLK); k++; end
            check("rcv_ready", bus.MEM_RECEIVE_READY, 1);
            if (stall) repeat (3) begin
                @(negedge CLK);
                check("rcv_ready_hold", {bus.MEM_RECEIVE_READY, bus.MEM_SEND_ADDR_VALID}, 2'b10);
            end
            bus.MEM_RECEIVE_VALID = 1'b1;
            bus.MEM_RECEIVE_DATA  = words[i];
            @(negedge CLK);
            bus.MEM_RECEIVE_VALID = 1'b0;
            bus.MEM_RECEIVE_DATA  = $urandom;
        end

        if (drop) begin
            seen = 1'b0;
            repeat (20) begin
                if (bus.SEND_PC_TO_QU_VALID || bus.SEND_PC_TO_FE_VALID || bus.SEND_PC_TO_MA_VALID)
                    seen = 1'b1;
                @(negedge CLK);
            end
            check("drop_no_valid", seen, 0);
            check("drop_idle", {bus.RECEIVE_PR_READY, bus.MEM_SEND_ADDR_VALID}, 2'b10);
`ifdef PACKET_LOADER_ERR_EN
            check("err_set", ERR, 1);
`endif
        end else begin
            e = exp_pkt_q.pop_front();
            k = 0;
            while (!(bus.SEND_PC_TO_QU_VALID || bus.SEND_PC_TO_FE_VALID || bus.SEND_PC_TO_MA_VALID)
                   && k < 60) begin @(negedge CLK); k++; end
            vld = {bus.SEND_PC_TO_QU_VALID, bus.SEND_PC_TO_FE_VALID, bus.SEND_PC_TO_MA_VALID};
            check("out_select", vld, 3'b100 >> e[176:175]);
            obs_pkt = vld[2] ? bus.SEND_PC_TO_QU_DATA :
                      vld[1] ? bus.SEND_PC_TO_FE_DATA : bus.SEND_PC_TO_MA_DATA;
            if (stall) repeat (3) begin
                @(negedge CLK);
                check("out_hold", {bus.SEND_PC_TO_QU_VALID, bus.SEND_PC_TO_FE_VALID,
                                   bus.SEND_PC_TO_MA_VALID, bus.SEND_PC_TO_QU_DATA},
                                  {vld, obs_pkt});
            end
            bus.SEND_PC_TO_QU_READY = 1'b1;
            bus.SEND_PC_TO_FE_READY = 1'b1;
            bus.SEND_PC_TO_MA_READY = 1'b1;
            @(negedge CLK);
            bus.SEND_PC_TO_QU_READY = 1'b0;
            bus.SEND_PC_TO_FE_READY = 1'b0;
            bus.SEND_PC_TO_MA_READY = 1'b0;
            check("packet", {e[176:175], obs_pkt}, e);
            if (!stall) check("latency", cyc - t0, 13);
            check("post_out", all_hs(), 6'b100000);
        end
    endtask

    initial begin
        bus.MEM_SEND_READY      = 1'b0;
        bus.MEM_RECEIVE_VALID   = 1'b0;
        bus.MEM_RECEIVE_DATA    = 32'd0;
        bus.RECEIVE_PR_VALID    = 1'b0;
        bus.RECEIVE_PR_DATA     = '0;
        bus.SEND_PC_TO_QU_READY = 1'b0;
        bus.SEND_PC_TO_FE_READY = 1'b0;
        bus.SEND_PC_TO_MA_READY = 1'b0;

        // reset state
        repeat (2) @(negedge CLK);
        check("reset_hs", all_hs(), 6'b000000);
        check("reset_wr", {bus.MEM_SEND_DATA_VALID, bus.MEM_SEND_DATA}, 33'd0);
        check("reset_data", bus.SEND_PC_TO_QU_DATA, 175'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_reset", all_hs(), 6'b100000);

        // EI / EXEC, spec address sequence
        run_packet(32'h2000_0000, {3'd0, 16'h0010, 32'h1111_2222, 32'h3333_4444, 25'h1AB_CDEF},
                   {2'd0, 8'h5A, 76'hFEDCBA9876543210ABC, 32'hDEAD_BEEF, 32'hCAFE_F00D, 25'h0123456},
                   17'h0ABCD, 1'b0, 1'b0);
        // FN / LEFT, template data2 survives
        run_packet(32'h1000_0000, {3'd2, 16'h0100, 32'h5555_6666, 32'h9999_0000, 25'h0F0F0F0},
                   {2'd1, 8'h33, 76'h0123456789ABCDEF012, 32'h7777_8888, 32'hAAAA_5555, 25'h1FFFFFF},
                   17'h00000, 1'b0, 1'b0);
        // MA / RIGHT, word 5 = 0xFFFF_8001
        run_packet(32'h0000_4000, {3'd3, 16'hFFFC, 32'h0BAD_F00D, 32'h1234_5678, 25'h1230001},
                   {2'd2, 8'hC3, 76'hA5A5A5A5A5A5A5A5A5A, 32'h1357_9BDF, 32'h2468_ACE0, 25'h0000001},
                   17'h1FFFF, 1'b0, 1'b0);
        // backpressure on every channel, same packet as the first case
        run_packet(32'h2000_0000, {3'd0, 16'h0010, 32'h1111_2222, 32'h3333_4444, 25'h1AB_CDEF},
                   {2'd0, 8'h5A, 76'hFEDCBA9876543210ABC, 32'hDEAD_BEEF, 32'hCAFE_F00D, 25'h0123456},
                   17'h0ABCD, 1'b1, 1'b0);
        // option 5 behaves as EXEC, address wraps past 2^32
        run_packet(32'hFFFF_FFF0, {3'd5, 16'h0020, 32'hFACE_B00C, 32'h0DDB_A11E, 25'h0000ABC},
                   {2'd1, 8'h01, 76'h13579BDF02468ACE135, 32'h0000_0001, 32'h8000_0000, 25'h1555555},
                   17'h12345, 1'b0, 1'b0);
        // illegal opmode 3 is discarded
        run_packet(32'h0000_0100, {3'd1, 16'h0004, 32'h1, 32'h2, 25'h3},
                   {2'd3, 8'hEE, 76'h0, 32'h0, 32'h0, 25'h0}, 17'h0, 1'b0, 1'b1);

        // reset in the middle of a load aborts it
        OPADDR = 32'h0000_0800;
        bus.RECEIVE_PR_VALID = 1'b1;
        bus.RECEIVE_PR_DATA  = {3'd0, 16'h0000, 32'h1, 32'h2, 25'h3};
        @(negedge CLK);
        bus.RECEIVE_PR_VALID = 1'b0;
        @(negedge CLK);
        check("midop_addr_valid", bus.MEM_SEND_ADDR_VALID, 1);
        RST = 1'b1;
        @(negedge CLK);
        check("midop_reset_hs", all_hs(), 6'b000000);
`ifdef PACKET_LOADER_ERR_EN
        check("err_cleared", ERR, 0);
`endif
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("midop_idle", all_hs(), 6'b100000);

        // normal traffic resumes after drop and abort
        run_packet(32'h3000_0000, {3'd1, 16'h1234, 32'hCCCC_DDDD, 32'hEEEE_FFFF, 25'h00000FF},
                   {2'd0, 8'h7F, 76'h0F0F0F0F0F0F0F0F0F0, 32'h4444_3333, 32'h2222_1111, 25'h0AAAAAA},
                   17'h0F0F0, 1'b0, 1'b0);

        check("queues_empty", {exp_addr_q.size() == 0, exp_pkt_q.size() == 0}, 2'b11);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
